ex_mem_stage: RTL and testbench

EX/MEM pipeline register and branch-resolution stage of the 64-bit pipelined core. It sits directly downstream of the 64-bit ALU and captures its result (O) and Zero flag with the EX-stage control bits. It resolves conditional branches (target = PC + (imm<<1), taken = branch & Zero) and squashes the younger wrong-path instructions that reach it after a taken branch.

---
 rtl/ex_mem_stage.sv | 111 +++++++++++
 tb/tb_ex_mem_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM register with branch resolution and wrong-path squash; define BRANCH_STATS_EN for branch counters
module ex_mem_stage #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic [63:0] ex_imm,
  input  logic [63:0] alu_result,
  input  logic        alu_zero,
  input  logic [63:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  output logic        mem_valid,
  output logic [63:0] mem_alu_result,
  output logic [63:0] mem_write_data,
  output logic [4:0]  mem_rd,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_reg_write,
  output logic        mem_mem_to_reg,
  output logic        mem_pc_src,
  output logic [63:0] mem_branch_target,
  output logic        squash_active,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken
);
  typedef enum logic {IDLE, SQUASH} state_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] alu;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
    logic        pc_src;
    logic [63:0] target;
  } mem_t;
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  mem_t       mem_q, mem_d;
  logic       taken, normal;
  assign taken  = ex_valid & ex_branch & alu_zero;
  assign normal = ~flush & ~stall & (state_q == IDLE) & ex_valid;
  // state and squash counter registers
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    cnt_q   <= reset ? 2'd0 : cnt_d;
  end
  // next state: flush aborts, squash counts down on advancing cycles, a loaded taken branch starts a squash
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end else if (!stall && state_q == SQUASH) begin
      cnt_d   = cnt_q - 2'd1;
      state_d = (cnt_q == 2'd1) ? IDLE : SQUASH;
    end else if (normal && taken) begin
      state_d = SQUASH;
      cnt_d   = 2'(SQUASH_DEPTH);
    end
  end
  // next stage contents: hold on stall, capture EX on a normal load, otherwise a zeroed bubble
  always_comb
    mem_d = flush ? '0 : stall ? mem_q : normal ?
      mem_t'{1'b1, alu_result, ex_rs2_data, ex_rd, ex_mem_read, ex_mem_write,
             ex_reg_write, ex_mem_to_reg, taken, ex_pc + (ex_imm << 1)} : '0;
  // stage register
  always_ff @(posedge clk)
    mem_q <= reset ? '0 : mem_d;
  assign mem_valid         = mem_q.valid;
  assign mem_alu_result    = mem_q.alu;
  assign mem_write_data    = mem_q.wdata;
  assign mem_rd            = mem_q.rd;
  assign mem_mem_read      = mem_q.mr;
  assign mem_mem_write     = mem_q.mw;
  assign mem_reg_write     = mem_q.rw;
  assign mem_mem_to_reg    = mem_q.m2r;
  assign mem_pc_src        = mem_q.pc_src;
  assign mem_branch_target = mem_q.target;
  assign squash_active     = state_q == SQUASH;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_q, tk_q;
  // branch counters advance only on normal loads, so squashed branches are never counted
  always_ff @(posedge clk) begin
    if (reset) begin
      br_q <= '0;
      tk_q <= '0;
    end else if (normal) begin
      br_q <= br_q + 32'(ex_branch);
      tk_q <= tk_q + 32'(taken);
    end
  end
  assign stat_branches = br_q;
  assign stat_taken    = tk_q;
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: model-checked directed and random test of ex_mem_stage
module tb_ex_mem_stage;
  localparam int DEPTH = 2;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic ex_valid, alu_zero, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [63:0] ex_pc, ex_imm, alu_result, ex_rs2_data;
  logic [4:0] ex_rd;
  logic mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_pc_src, squash_active;
  logic [63:0] mem_alu_result, mem_write_data, mem_branch_target;
  logic [4:0] mem_rd;
  logic [31:0] stat_branches, stat_taken;
  int total = 0, bad = 0;
  logic go = 1'b0;

  ex_mem_stage #(.SQUASH_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .alu_result(alu_result),
    .alu_zero(alu_zero), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_pc_src(mem_pc_src), .mem_branch_target(mem_branch_target), .squash_active(squash_active),
    .stat_branches(stat_branches), .stat_taken(stat_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [63:0] alu, wd; logic [4:0] rd;
    logic mr, mw, rw, m2r, pcs; logic [63:0] tgt;
  } exp_t;
  exp_t m;
  int sq;
  logic [31:0] nb, nt;

  // reference: bubbles after a taken branch counted as plain remaining-slots integer
  always @(posedge clk) begin
    if (reset) begin
      m <= '0; sq <= 0; nb <= '0; nt <= '0;
    end else if (flush) begin
      m <= '0; sq <= 0;
    end else if (!stall) begin
      if (sq > 0) begin
        m <= '0; sq <= sq - 1;
      end else if (!ex_valid) begin
        m <= '0;
      end else begin
        m.v <= 1'b1; m.alu <= alu_result; m.wd <= ex_rs2_data; m.rd <= ex_rd;
        m.mr <= ex_mem_read; m.mw <= ex_mem_write; m.rw <= ex_reg_write; m.m2r <= ex_mem_to_reg;
        m.pcs <= ex_branch && alu_zero;
        m.tgt <= ex_pc + ex_imm * 64'd2;
        sq <= (ex_branch && alu_zero) ? DEPTH : 0;
        nb <= nb + (ex_branch ? 32'd1 : 32'd0);
        nt <= nt + ((ex_branch && alu_zero) ? 32'd1 : 32'd0);
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", n, a, e, $time);
    end
  endtask

  // compare every output against the reference each cycle
  always @(negedge clk) if (go) begin
    chk("valid", 64'(mem_valid), 64'(m.v));
    chk("alu", mem_alu_result, m.alu);
    chk("wdata", mem_write_data, m.wd);
    chk("rd", 64'(mem_rd), 64'(m.rd));
    chk("ctl", 64'({mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg}), 64'({m.mr, m.mw, m.rw, m.m2r}));
    chk("pc_src", 64'(mem_pc_src), 64'(m.pcs));
    chk("target", mem_branch_target, m.tgt);
    chk("squash", 64'(squash_active), 64'(sq > 0));
`ifdef BRANCH_STATS_EN
    chk("stat_br", 64'(stat_branches), 64'(nb));
    chk("stat_tk", 64'(stat_taken), 64'(nt));
`else
    chk("stat_br", 64'(stat_branches), 64'd0);
    chk("stat_tk", 64'(stat_taken), 64'd0);
`endif
  end

  // ctl = {branch, mem_read, mem_write, reg_write, mem_to_reg}
  task automatic ins(input logic v, input logic [63:0] pc, imm, alu, input logic z,
                     input logic [4:0] rd, input logic [4:0] ctl);
    ex_valid = v; ex_pc = pc; ex_imm = imm; alu_result = alu; alu_zero = z;
    ex_rs2_data = ~alu; ex_rd = rd;
    {ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg} = ctl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd();
    ins($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
        1'($urandom), 5'($urandom), 5'($urandom));
  endtask

  initial begin
    rnd();
    step();
    go = 1'b1;
    rnd();
    step();
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_alu", mem_alu_result, 64'd0);
    chk("rst_squash", 64'(squash_active), 64'd0);
    chk("rst_stat", 64'(stat_branches), 64'd0);
    reset = 1'b0;
    ins(1, 64'h40, 64'h0, 64'h0000_0000_DEAD_BEEF, 0, 5'd5, 5'b00010);
    step();
    chk("load_alu", mem_alu_result, 64'hDEAD_BEEF);
    chk("load_rd", 64'(mem_rd), 64'd5);
    chk("load_rw", 64'(mem_reg_write), 64'd1);
    chk("load_valid", 64'(mem_valid), 64'd1);
    // taken branch then two squashed slots
    ins(1, 64'h100, 64'h8, 64'h0, 1, 5'd0, 5'b10000);
    step();
    chk("tk_pcsrc", 64'(mem_pc_src), 64'd1);
    chk("tk_target", mem_branch_target, 64'h110);
    chk("tk_squash", 64'(squash_active), 64'd1);
    ins(1, 64'h104, 64'h0, 64'h11, 0, 5'd3, 5'b00010);
    step();
    chk("sq1_valid", 64'(mem_valid), 64'd0);
    step();
    chk("sq2_valid", 64'(mem_valid), 64'd0);
    step();
    chk("resume_alu", mem_alu_result, 64'h11);
    // not taken, and target wrap
    ins(1, 64'h100, 64'h8, 64'h0, 0, 5'd0, 5'b10000);
    step();
    chk("nt_pcsrc", 64'(mem_pc_src), 64'd0);
    chk("nt_target", mem_branch_target, 64'h110);
    chk("nt_squash", 64'(squash_active), 64'd0);
    ins(1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h0, 0, 5'd0, 5'b10000);
    step();
    chk("wrap_target", mem_branch_target, 64'h10);
    // stall for 3 cycles inside a squash
    ins(1, 64'h100, 64'h8, 64'h0, 1, 5'd0, 5'b10000);
    step();
    stall = 1'b1;
    ins(1, 64'h200, 64'h0, 64'h22, 0, 5'd7, 5'b00010);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pcsrc", 64'(mem_pc_src), 64'd1);
      chk("stall_target", mem_branch_target, 64'h110);
      chk("stall_squash", 64'(squash_active), 64'd1);
    end
    stall = 1'b0;
    step();
    chk("stq1_valid", 64'(mem_valid), 64'd0);
    step();
    chk("stq2_valid", 64'(mem_valid), 64'd0);
    step();
    chk("st_resume", mem_alu_result, 64'h22);
    // flush mid-squash, then flush together with stall
    ins(1, 64'h100, 64'h8, 64'h0, 1, 5'd0, 5'b10000);
    step();
    ins(1, 64'h300, 64'h0, 64'h33, 0, 5'd9, 5'b00010);
    step();
    flush = 1'b1;
    step();
    chk("fl_valid", 64'(mem_valid), 64'd0);
    chk("fl_squash", 64'(squash_active), 64'd0);
    flush = 1'b0;
    step();
    chk("fl_resume", mem_alu_result, 64'h33);
    flush = 1'b1;
    stall = 1'b1;
    step();
    chk("flst_valid", 64'(mem_valid), 64'd0);
    flush = 1'b0;
    stall = 1'b0;
    // branch statistics: second branch lands in the squash window
    reset = 1'b1;
    step();
    reset = 1'b0;
    ins(1, 64'h400, 64'h4, 64'h0, 1, 5'd0, 5'b10000);
    step();
    step();
    ins(1, 64'h410, 64'h0, 64'h1, 0, 5'd1, 5'b00010);
    step();
    ins(1, 64'h420, 64'h4, 64'h0, 0, 5'd0, 5'b10000);
    step();
    ins(0, 64'h0, 64'h0, 64'h0, 0, 5'd0, 5'b00000);
    step();
`ifdef BRANCH_STATS_EN
    chk("lit_stat_br", 64'(stat_branches), 64'd2);
    chk("lit_stat_tk", 64'(stat_taken), 64'd1);
`else
    chk("lit_stat_br", 64'(stat_branches), 64'd0);
    chk("lit_stat_tk", 64'(stat_taken), 64'd0);
`endif
    // random traffic with occasional stall, flush and reset
    for (int i = 0; i < 80; i++) begin
      rnd();
      stall = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 11) == 0;
      reset = $urandom_range(0, 39) == 0;
      step();
    end
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
